mux_scan_controller: RTL
========================

// Module: mux_scan_controller
//
// PURPOSE
// Upstream sequencer for the 8:1 mux (MUX_8x1). It drives selects s2/s1/s0 through
// channels 0..LAST_CH in order, waits a settle time on each channel, then samples
// the mux output. The sampled bits are assembled into a parallel word, which is
// presented with a one-cycle done pulse. A start/busy/done handshake connects it to
// the controlling logic.
//
// PARAMETERS
// SETTLE_CYCLES  2  cycles select is held before sampling; legal 1..15
// LAST_CH        7  highest channel scanned; legal 0..7
//
// PORTS
// clk      in   1  rising-edge clock
// rst      in   1  asynchronous reset, active-high
// start    in   1  scan request; accepted only in IDLE
// mux_out  in   1  output of the 8:1 mux
// s0       out  1  select LSB to mux
// s1       out  1  select bit 1 to mux
// s2       out  1  select MSB to mux
// busy     out  1  high while a scan is in progress (SETTLE/SAMPLE)
// done     out  1  one-cycle pulse; data valid from this cycle on
// data     out  8  captured word; bit k = mux_out sampled on channel k
//
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, {s2,s1,s0}=000, busy=0, done=0,
//   data=8'h00, settle counter=0, capture register=0.
// - Select encoding: {s2,s1,s0} = channel index in binary, s0 = LSB.
//   Select is 000 in IDLE and DONE. All outputs are registered.
// - FSM states: IDLE, SETTLE, SAMPLE, DONE.
//   IDLE: start=1 -> SETTLE; ch=0; cnt=0; capture register cleared.
//   SETTLE: lasts exactly SETTLE_CYCLES cycles; cnt counts 0..SETTLE_CYCLES-1; -> SAMPLE.
//   SAMPLE: one cycle; cap[ch] <= mux_out at the edge ending the cycle.
//     ch<LAST_CH: ch<=ch+1, cnt<=0, -> SETTLE.
//     ch==LAST_CH: data <= capture with new bit, -> DONE.
//   DONE: one cycle, done=1, busy=0; -> IDLE unconditionally.
// - Per channel: SETTLE_CYCLES+1 cycles. With start sampled at edge E,
//   done is high in the cycle after edge E+(LAST_CH+1)*(SETTLE_CYCLES+1).
//   Defaults: E+24.
// - busy=1 in SETTLE/SAMPLE, 0 in IDLE/DONE.
// - start is ignored in SETTLE, SAMPLE and DONE (no queueing).
//   When start is held high, the next scan begins on the IDLE cycle after DONE.
// - data holds its value between scans and changes only on entry to DONE.
//   Bits above LAST_CH are always 0.
// - Channel index never wraps; scanning stops at LAST_CH.
// - rst asserted mid-scan: abort immediately, all outputs take reset values,
//   no done pulse, data=00.
// - mux_out may change at any time; only its value at the SAMPLE edge is captured.
//
// TESTING
// 1. rst=1 for 3 cycles, start=1 -> s=000, busy=0, done=0, data=00; start ignored.
// 2. Bench mux i[7:0]=8'hA6; 1-cycle start pulse -> sel steps 0..7, each held
//    3 cycles; done 1 cycle at E+24; data=8'hA6; busy falls with done.
// 3. start held high over two scans -> exactly one done per scan;
//    second scan begins the cycle after done; data=8'hA6 both times.
// 4. rst pulse while sel=4 -> outputs reset at once, no done, data=00;
//    a new start with i=8'h5A -> data=8'h5A.
// 5. Toggle i3 during channel 3 SETTLE; final value 1 at SAMPLE edge -> data[3]=1.
// 6. Instance with LAST_CH=3, SETTLE_CYCLES=1, i=8'hFF -> sel 0..3; done at E+8;
//    data=8'h0F.

Source files
------------

// File: rtl/mux_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_controller
// Desc     : Steps 8:1 mux selects over channels 0..LAST_CH, samples each
//            channel after a settle time and returns the bits as one word.
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan_controller #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LAST_CH       = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mux_out,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       busy,
    output logic       done,
    output logic [7:0] data
);

    localparam logic [2:0] c_last_ch     = 3'(LAST_CH);
    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_ch,    w_ch_nxt;
    logic [3:0] r_cnt,   w_cnt_nxt;
    logic [7:0] r_cap,   w_cap_nxt;
    logic [7:0] r_data,  w_data_nxt;
    logic [2:0] r_sel,   w_sel_nxt;
    logic       r_busy,  w_busy_nxt;
    logic       r_done,  w_done_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_cnt_nxt   = r_cnt;
        w_cap_nxt   = r_cap;
        w_data_nxt  = r_data;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SETTLE;
                    w_ch_nxt    = 3'd0;
                    w_cnt_nxt   = 4'd0;
                    w_cap_nxt   = 8'h00;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == c_settle_last) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_SAMPLE: begin
                w_cap_nxt[r_ch] = mux_out;
                if (r_ch < c_last_ch) begin
                    w_ch_nxt    = r_ch + 3'd1;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    // Word is published with the freshly sampled last bit included
                    w_data_nxt  = w_cap_nxt;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave the flops directly
        w_busy_nxt = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SAMPLE);
        w_done_nxt = (w_state_nxt == ST_DONE);
        w_sel_nxt  = w_busy_nxt ? w_ch_nxt : 3'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ch    <= 3'd0;
            r_cnt   <= 4'd0;
            r_cap   <= 8'h00;
            r_data  <= 8'h00;
            r_sel   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cap   <= w_cap_nxt;
            r_data  <= w_data_nxt;
            r_sel   <= w_sel_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign s0   = r_sel[0];
    assign s1   = r_sel[1];
    assign s2   = r_sel[2];
    assign busy = r_busy;
    assign done = r_done;
    assign data = r_data;

endmodule
`default_nettype wire
